// File: rtl/dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_arb_pkg
// Purpose  : Shared state, grant and wishbone cycle-type encodings for the
//            CPU / video / sound memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_VID  = 2'd2,
        ST_SND  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_CPU  = 2'd1;
    localparam logic [1:0] GRANT_VID  = 2'd2;
    localparam logic [1:0] GRANT_SND  = 2'd3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            ST_CPU:  return GRANT_CPU;
            ST_VID:  return GRANT_VID;
            ST_SND:  return GRANT_SND;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_arb_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module   : dma_arb_burst_ctr
// Purpose  : Word counter for aligned DMA bursts; supplies the low address
//            bits and flags the final word of the burst.
// Revision : 1.0 - initial release
// ============================================================================
module dma_arb_burst_ctr
    import dma_arb_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_inc,
    output logic [$clog2(BURST_LEN)-1:0] o_low,
    output logic                         o_last
);

    localparam int LOW_W = $clog2(BURST_LEN);

    logic [LOW_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + LOW_W'(1);
        end
    end

    assign o_low  = r_cnt;
    assign o_last = (r_cnt == LOW_W'(BURST_LEN - 1));

endmodule
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_arbiter
// Purpose  : Registered grant FSM sharing one wishbone memory port between the
//            CPU and the video/sound DMA channels. Optional anti-starvation
//            slot for the CPU when DMA_ARB_FAIRNESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dma_arbiter
    import dma_arb_pkg::*;
#(
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clkcpu,
    input  logic        rst_i,
    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [21:0] cpu_addr,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [21:0] vid_addr,
    output logic        vid_ack,
    input  logic        snd_req,
    input  logic [21:0] snd_addr,
    output logic        snd_ack,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [2:0]  mem_cti_o,
    output logic [21:0] mem_addr_o,
    input  logic        mem_ack_i,
    output logic [1:0]  grant_o
);

    localparam int LOW_W = $clog2(BURST_LEN);

    if (BURST_LEN < 2 || BURST_LEN > 8 || (BURST_LEN & (BURST_LEN - 1)) != 0 ||
        STARVE_LIMIT < 1) begin : g_bad_params
        $error("dma_arbiter: unsupported BURST_LEN or STARVE_LIMIT");
    end

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic             r_we;
    logic [3:0]       r_sel;
    logic [21:0]      r_addr;
    logic [LOW_W-1:0] w_low;
    logic             w_last;
    logic             w_cpu_req;
    logic             w_force_cpu;
    logic             w_busy;
    logic             w_dma;

    assign w_cpu_req = cpu_cyc & cpu_stb;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_dma     = (r_state == ST_VID) || (r_state == ST_SND);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_force_cpu)    w_next = ST_CPU;
                else if (vid_req)   w_next = ST_VID;
                else if (snd_req)   w_next = ST_SND;
                else if (w_cpu_req) w_next = ST_CPU;
            end
            ST_CPU:  if (mem_ack_i)           w_next = ST_IDLE;
            ST_VID,
            ST_SND:  if (mem_ack_i && w_last) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // DMA addresses are captured whole; the low bits are replaced by the
    // burst counter on the way out, which keeps every burst aligned.
    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) begin
                case (w_next)
                    ST_CPU: begin
                        r_we   <= cpu_we;
                        r_sel  <= cpu_sel;
                        r_addr <= cpu_addr;
                    end
                    ST_VID: begin
                        r_we   <= 1'b0;
                        r_sel  <= 4'hF;
                        r_addr <= vid_addr;
                    end
                    ST_SND: begin
                        r_we   <= 1'b0;
                        r_sel  <= 4'hF;
                        r_addr <= snd_addr;
                    end
                    default: ;
                endcase
            end
        end
    end

    dma_arb_burst_ctr #(
        .BURST_LEN (BURST_LEN)
    ) u_burst_ctr (
        .clk    (clkcpu),
        .rst    (rst_i),
        .i_load (r_state == ST_IDLE),
        .i_inc  (mem_ack_i & w_dma),
        .o_low  (w_low),
        .o_last (w_last)
    );

`ifdef DMA_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve;

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            r_starve <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_next == ST_CPU) begin
                r_starve <= '0;
            end else if ((w_next == ST_VID || w_next == ST_SND) &&
                         r_starve != STARVE_W'(STARVE_LIMIT)) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end

    assign w_force_cpu = w_cpu_req && (r_starve == STARVE_W'(STARVE_LIMIT));
`else
    assign w_force_cpu = 1'b0;
`endif

    assign mem_cyc_o  = w_busy;
    assign mem_stb_o  = w_busy;
    assign mem_we_o   = w_busy & r_we;
    assign mem_sel_o  = w_busy ? r_sel : 4'h0;
    assign mem_cti_o  = w_dma ? (w_last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign mem_addr_o = !w_busy ? 22'h0 :
                        w_dma   ? {r_addr[21:LOW_W], w_low} : r_addr;
    assign grant_o    = grant_of(r_state);

    // The only combinational input-to-output path.
    assign cpu_ack = mem_ack_i & (r_state == ST_CPU);
    assign vid_ack = mem_ack_i & (r_state == ST_VID);
    assign snd_ack = mem_ack_i & (r_state == ST_SND);

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_arbiter
// Purpose  : Self-checking bench for dma_arbiter; expected memory beats are
//            queued with each stimulus and compared as the bench slave acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_arbiter;

    localparam int BL = 4;

    logic        clkcpu = 1'b0;
    logic        rst_i  = 1'b1;
    logic        cpu_cyc = 1'b0, cpu_stb = 1'b0, cpu_we = 1'b0;
    logic [3:0]  cpu_sel = 4'h0;
    logic [21:0] cpu_addr = '0;
    logic        cpu_ack;
    logic        vid_req = 1'b0;
    logic [21:0] vid_addr = '0;
    logic        vid_ack;
    logic        snd_req = 1'b0;
    logic [21:0] snd_addr = '0;
    logic        snd_ack;
    logic        mem_cyc_o, mem_stb_o, mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [2:0]  mem_cti_o;
    logic [21:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [1:0]  grant_o;

    always #5 clkcpu = ~clkcpu;

    dma_arbiter #(
        .BURST_LEN    (BL),
        .STARVE_LIMIT (3)
    ) dut (
        .clkcpu     (clkcpu),
        .rst_i      (rst_i),
        .cpu_cyc    (cpu_cyc),
        .cpu_stb    (cpu_stb),
        .cpu_we     (cpu_we),
        .cpu_sel    (cpu_sel),
        .cpu_addr   (cpu_addr),
        .cpu_ack    (cpu_ack),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .snd_req    (snd_req),
        .snd_addr   (snd_addr),
        .snd_ack    (snd_ack),
        .mem_cyc_o  (mem_cyc_o),
        .mem_stb_o  (mem_stb_o),
        .mem_we_o   (mem_we_o),
        .mem_sel_o  (mem_sel_o),
        .mem_cti_o  (mem_cti_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .grant_o    (grant_o)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic [21:0] addr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_dma(input logic [1:0] g, input logic [21:0] a);
        beat_t       b;
        logic [21:0] base;
        base = a & ~22'(BL - 1);
        for (int i = 0; i < BL; i++) begin
            b.gnt  = g;
            b.addr = base + 22'(i);
            b.cti  = (i == BL - 1) ? 3'b111 : 3'b010;
            b.we   = 1'b0;
            b.sel  = 4'hF;
            exp_q.push_back(b);
        end
    endtask

    task automatic push_cpu(input logic [21:0] a, input logic we, input logic [3:0] sel);
        beat_t b;
        b.gnt  = 2'd1;
        b.addr = a;
        b.cti  = 3'b000;
        b.we   = we;
        b.sel  = sel;
        exp_q.push_back(b);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"},   mem_cyc_o,  0);
        chk({tag, "_stb"},   mem_stb_o,  0);
        chk({tag, "_we"},    mem_we_o,   0);
        chk({tag, "_sel"},   mem_sel_o,  0);
        chk({tag, "_cti"},   mem_cti_o,  0);
        chk({tag, "_addr"},  mem_addr_o, 0);
        chk({tag, "_grant"}, grant_o,    0);
        chk({tag, "_acks"},  {cpu_ack, vid_ack, snd_ack}, 0);
    endtask

    // Acts as the memory slave: acks n beats with a fixed wait count and
    // checks each acked beat against the head of the expectation queue.
    task automatic serve(input int n, input int waits, input bit end_idle);
        int    guard;
        beat_t e;
        guard = 0;
        @(negedge clkcpu);
        #1;
        while (!(mem_cyc_o && mem_stb_o) && guard < 50) begin
            @(negedge clkcpu);
            #1;
            guard++;
        end
        chk("grant_timeout", guard < 50, 1);
        for (int b = 0; b < n; b++) begin
            if (b > 0) @(negedge clkcpu);
            repeat (waits) begin
                mem_ack_i = 1'b0;
                #1;
                chk("stb_held", mem_stb_o, 1);
                @(negedge clkcpu);
            end
            mem_ack_i = 1'b1;
            #1;
            if (exp_q.size() == 0) begin
                chk("queue_underrun", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("beat_grant", grant_o,    e.gnt);
                chk("beat_addr",  mem_addr_o, e.addr);
                chk("beat_cti",   mem_cti_o,  e.cti);
                chk("beat_we",    mem_we_o,   e.we);
                chk("beat_sel",   mem_sel_o,  e.sel);
                chk("cpu_ack",    cpu_ack,    e.gnt == 2'd1);
                chk("vid_ack",    vid_ack,    e.gnt == 2'd2);
                chk("snd_ack",    snd_ack,    e.gnt == 2'd3);
            end
        end
        if (end_idle) begin
            @(negedge clkcpu);
            mem_ack_i = 1'b0;
            #1;
            chk("idle_cyc",   mem_cyc_o, 0);
            chk("idle_grant", grant_o,   0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clkcpu);
        #1;
        chk_reset_outputs("reset");
        rst_i = 1'b0;

        // CPU only: write with two slave wait cycles
        @(negedge clkcpu);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1;
        cpu_sel = 4'b0011; cpu_addr = 22'h001234;
        push_cpu(22'h001234, 1'b1, 4'b0011);
        serve(1, 2, 1'b1);
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        chk("cpu_only_drained", exp_q.size(), 0);

        // Simultaneous requests: video, then sound, then CPU
        @(negedge clkcpu);
        vid_req = 1'b1; vid_addr = 22'h000200;
        snd_req = 1'b1; snd_addr = 22'h000310;
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0;
        cpu_sel = 4'hF; cpu_addr = 22'h000055;
        push_dma(2'd2, 22'h000200);
        serve(BL, 0, 1'b1);
        vid_req = 1'b0;
        push_dma(2'd3, 22'h000310);
        serve(BL, 1, 1'b1);
        snd_req = 1'b0;
        push_cpu(22'h000055, 1'b0, 4'hF);
        serve(1, 0, 1'b1);
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        chk("simul_drained", exp_q.size(), 0);

        // Unaligned video address is aligned down
        @(negedge clkcpu);
        vid_req = 1'b1; vid_addr = 22'h000107;
        push_dma(2'd2, 22'h000107);
        serve(BL, 0, 1'b1);
        vid_req = 1'b0;
        chk("unaligned_drained", exp_q.size(), 0);

        // Reset during the second word of a sound burst
        @(negedge clkcpu);
        snd_req = 1'b1; snd_addr = 22'h000400;
        exp_q.push_back('{gnt: 2'd3, addr: 22'h000400, cti: 3'b010, we: 1'b0, sel: 4'hF});
        serve(1, 0, 1'b0);
        @(negedge clkcpu);
        mem_ack_i = 1'b0;
        snd_req   = 1'b0;
        rst_i     = 1'b1;
        #1;
        chk("snd_word1_addr", mem_addr_o, 22'h000401);
        @(negedge clkcpu);
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("midburst_reset");
        vid_req = 1'b1; vid_addr = 22'h00040A;
        push_dma(2'd2, 22'h00040A);
        serve(BL, 0, 1'b1);
        vid_req = 1'b0;
        chk("post_reset_drained", exp_q.size(), 0);

        // Starvation: video held high with the CPU requesting
        @(negedge clkcpu);
        rst_i = 1'b1;
        @(negedge clkcpu);
        rst_i = 1'b0;
        vid_req = 1'b1; vid_addr = 22'h000800;
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1;
        cpu_sel = 4'hC; cpu_addr = 22'h000077;
`ifdef DMA_ARB_FAIRNESS_EN
        for (int k = 0; k < 3; k++) begin
            push_dma(2'd2, 22'h000800);
            serve(BL, 0, 1'b1);
        end
        push_cpu(22'h000077, 1'b1, 4'hC);
        serve(1, 0, 1'b1);
        vid_req = 1'b0;
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
`else
        for (int k = 0; k < 5; k++) begin
            push_dma(2'd2, 22'h000800);
            serve(BL, 0, 1'b1);
        end
        vid_req = 1'b0;
        push_cpu(22'h000077, 1'b1, 4'hC);
        serve(1, 0, 1'b1);
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
`endif
        chk("starve_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dma_arbiter.md
# dma_arbiter

Shares the single wishbone memory port between the CPU and the two VIDC DMA channels (video and sound). It sits between the CPU bus decode and the SDRAM wishbone slave, and replaces ad-hoc request muxing with one registered grant state machine. CPU accesses are single-word classic cycles. DMA requests are fixed-length, aligned, incrementing bursts.

## Interface
Parameters:
- BURST_LEN, 4 — words per DMA burst; must be a power of two, 2..8.
- STARVE_LIMIT, 3 — consecutive DMA bursts allowed before the CPU is forced a slot (only with DMA_ARB_FAIRNESS_EN).

Ports:
- clkcpu  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- cpu_cyc, cpu_stb, cpu_we  in  1  CPU wishbone cycle/strobe/write.
- cpu_sel  in  4  CPU byte lanes.
- cpu_addr  in  22  CPU word address [23:2].
- cpu_ack  out  1  CPU acknowledge.
- vid_req  in  1  video DMA request, level.
- vid_addr  in  22  video burst word address [23:2].
- vid_ack  out  1  one pulse per video word delivered.
- snd_req, snd_addr, snd_ack  —  sound channel; same widths and semantics as the video channel.
- mem_cyc_o, mem_stb_o, mem_we_o  out  1  memory wishbone master.
- mem_sel_o  out  4  byte lanes.
- mem_cti_o  out  3  cycle type.
- mem_addr_o  out  22  word address.
- mem_ack_i  in  1  memory acknowledge.
- grant_o  out  2  current owner: 0 = none, 1 = CPU, 2 = video, 3 = sound.

## Operation
- **States:** IDLE, CPU, VID, SND.
- **Decision in IDLE:**
  - Priority is fixed: vid_req > snd_req > (cpu_cyc & cpu_stb).
  - If none is asserted, remain in IDLE.
- **CPU state:**
  - Drives the single classic cycle: cti = 3'b000, mem_we_o = cpu_we, mem_sel_o = cpu_sel.
  - mem_addr_o = cpu_addr. Address and control are registered at grant and held until ack.
  - On the first mem_ack_i, the state goes to IDLE.
- **VID/SND states:**
  - Read-only bursts: mem_we_o = 0, sel = 4'hF.
  - Upper address bits [23:2+log2(BURST_LEN)] are latched from the channel address at grant.
  - Lower bits come from an internal word counter that starts at 0. Requester low bits are ignored, so every burst is aligned and never crosses a BURST_LEN boundary.
  - Counter increments on each mem_ack_i.
  - cti = 3'b010 for words 0..BURST_LEN-2 and 3'b111 for the last word.
  - After the last ack, the state goes to IDLE.
- **Acknowledge routing:**
  - cpu_ack = mem_ack_i & (state==CPU); vid_ack and snd_ack are formed the same way.
  - This path is combinational; no other input-to-output path is combinational.
- **Request drop mid-burst:** if vid_req or snd_req falls during a burst, the burst still completes. Data delivered after the drop is discarded by VIDC.
- **CPU abandons its cycle:** if cpu_cyc drops while in the CPU state, the arbiter still waits for mem_ack_i. It never truncates a memory cycle, and cpu_ack is still pulsed.
- **Idle turnaround:** there is always at least one cycle in IDLE between transactions. mem_cyc_o is low for that cycle.
- **Reset:** rst_i high at any edge, including mid-burst, forces IDLE and zeroes the counter on that edge. Reset values are:
  - mem_cyc_o = mem_stb_o = mem_we_o = 0.
  - mem_sel_o = 0, mem_cti_o = 0, mem_addr_o = 0.
  - grant_o = 0.
  - cpu_ack, vid_ack and snd_ack are 0, because they are gated by state.

## Timing
- A request sampled high in IDLE at edge N sets mem_cyc_o and mem_stb_o high from edge N, i.e. visible in cycle N+1. grant_o updates on the same edge.
- A transaction whose final ack arrives in cycle M returns to IDLE at edge M; mem_cyc_o is low in cycle M+1.
- A new grant can then take effect at edge M+1.
- With zero-wait memory (ack asserted every cycle of stb):
  - DMA burst: BURST_LEN cycles of cyc, plus 1 idle cycle.
  - CPU access: 1 cycle of cyc, plus 1 idle cycle.
  - Worst-case CPU latency with the fairness counter disabled is unbounded.
- mem_stb_o stays high throughout a burst. Wait states are inserted solely by the slave withholding mem_ack_i.

## Configuration
- **DMA_ARB_FAIRNESS_EN defined:**
  - A saturating counter counts consecutive DMA grants and clears on any CPU grant.
  - When the count equals STARVE_LIMIT and a CPU request is pending in IDLE, the CPU wins over vid/snd for that one decision.
  - Worst-case CPU wait is STARVE_LIMIT × (BURST_LEN+1) cycles plus slave wait states.
- **DMA_ARB_FAIRNESS_EN undefined:** strict fixed priority; the counter logic is absent.

## Structure
- Shared package dma_arb_pkg holds:
  - the state enum (IDLE/CPU/VID/SND);
  - the grant encodings, which equal the grant_o values;
  - cti constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
- One sub-module, dma_arb_burst_ctr, provides the word counter:
  - inputs: load-to-zero, ack increment;
  - outputs: low address bits and a last-word flag.
- The top module holds the FSM, the address/control registers, the ack routing and the fairness counter.

## Test plan
- **CPU only:** cpu_cyc/stb with write to 22'h001234, sel 4'b0011, slave acks after 2 wait cycles. Required: a single cycle with cti 000, we 1, addr 22'h001234; exactly one cpu_ack; grant_o 1 → 0.
- **Simultaneous requests:** vid_req, snd_req and CPU all raised on the same edge. Required grant order: video, sound, CPU. Each DMA burst is 4 acks with cti 010,010,010,111; one idle cycle between owners.
- **Unaligned video address:** vid_addr = 22'h000107. Required mem_addr_o sequence: 104, 105, 106, 107; exactly 4 vid_ack pulses; no snd_ack or cpu_ack.
- **Reset during burst:** rst_i high during the second word of a sound burst. Required at the next edge: all outputs at their reset values, grant_o 0. A fresh video request afterwards starts again at low bits 0.
- **Fairness (DMA_ARB_FAIRNESS_EN, STARVE_LIMIT 3):** vid_req held permanently high with the CPU requesting. Required: the CPU is granted after exactly 3 video bursts. Without the macro, the CPU is never granted while vid_req stays high.
